// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions.
// Fetch optionally uses FETCH_BYPASS_EN for the empty-queue fast path.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
// Master is the fetch stage, slave is the memory.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/clear and occupancy count.
// Clear wins over a same-cycle push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = logic [XLEN-1:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  T                       din,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] P1 = AW'(1);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] CF = CW'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CF);
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write, no reset needed on data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P1;
      if (do_pop)  rd_ptr <= rd_ptr + P1;
      if (do_push && !do_pop)      count <= count + C1;
      else if (do_pop && !do_push) count <= count - C1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, in-order imem requests, prefetch
// queue and IF/ID register. Optional macro: FETCH_BYPASS_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  fetch_stage_if.master    imem,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  output logic [XLEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] LIM = CW'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_q;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   p_count;
  logic [CW-1:0]   used;
  logic [CW-1:0]   out_nxt;
  logic [XLEN-1:0] p_dout;
  fetch_entry_t    q_din;
  fetch_entry_t    q_dout;
  logic            req;
  logic            accept;
  logic            rsp;
  logic            dropping;
  logic            keep;
  logic            q_empty;
  logic            q_push;
  logic            q_pop;
  logic            d_adv;
  logic            bypass;

  // Pending-PC FIFO occupancy doubles as the outstanding count.
  assign used     = p_count + q_count;
  assign req      = !reset && (used < LIM);
  assign accept   = req && imem.imem_ready;
  assign rsp      = imem.imem_rvalid && (p_count != '0);
  assign dropping = (drop_q != '0);
  assign keep     = rsp && !dropping;
  assign q_empty  = (q_count == '0);
  assign d_adv    = !FlushD && !StallD;
  assign out_nxt  = p_count + (accept ? ONE : '0) - (rsp ? ONE : '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = keep && q_empty && d_adv && !PCSrcE;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = keep && !bypass;
  assign q_pop  = d_adv && !q_empty;
  assign q_din  = '{instr: imem.imem_rdata, pc: p_dout};

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pend (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rsp),
    .clear (1'b0),
    .din   (pc_q),
    .dout  (p_dout),
    .count (p_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (PCSrcE),
    .din   (q_din),
    .dout  (q_dout),
    .count (q_count)
  );

  // Fetch PC: redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset)       pc_q <= RESET_PC;
    else if (PCSrcE) pc_q <= PCTargetE;
    else if (accept) pc_q <= pc_q + 32'd4;
  end

  // Discard count: a redirect marks every in-flight word stale.
  always_ff @(posedge clk) begin
    if (reset)                 drop_q <= '0;
    else if (PCSrcE)           drop_q <= out_nxt;
    else if (rsp && dropping)  drop_q <= drop_q - ONE;
  end

  // IF/ID register: flush, stall, then load or bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= 32'd4;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (bypass) begin
        InstrD   <= imem.imem_rdata;
        PCD      <= p_dout;
        PCPlus4D <= p_dout + 32'd4;
        ValidD   <= 1'b1;
      end else if (!q_empty) begin
        InstrD   <= q_dout.instr;
        PCD      <= q_dout.pc;
        PCPlus4D <= q_dout.pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed tables, corner
// sequences and randomized traffic against an in-order PC model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (bus),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[31:2] ^ 30'h2A5C3C3, 2'b11};
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc = 0;
  int    lat = 1;
  int    last_due = 0;
  int    n_new = 0;

  bit          c_rst = 1, c_stall = 0, c_flush = 0, c_redir = 0, c_ready = 1;
  logic [31:0] c_tgt = 0;
  bit          rsp_now;

  bit          s_req, s_valid;
  logic [31:0] s_addr, s_pcd;

  logic [31:0] exp_pc = RPC;
  bit          md_valid = 0;
  logic [31:0] md_pc = 0;
  bit          p_stall = 0, p_flush = 0;

  task automatic monitor();
    if (c_rst) begin
      check("req_in_reset", s_req, 0);
      mq.delete();
      exp_pc = RPC;
      md_valid = 0;
      p_stall = 0;
      p_flush = 0;
      return;
    end
    if (p_stall && !p_flush) begin
      check("hold_valid", ValidD, md_valid);
      if (md_valid) begin
        check("hold_pcd", PCD, md_pc);
        check("hold_instr", InstrD, memf(md_pc));
      end
    end else if (ValidD) begin
      check("pcd", PCD, exp_pc);
      check("instr", InstrD, memf(exp_pc));
      check("pcplus4", PCPlus4D, exp_pc + 32'd4);
      md_valid = 1;
      md_pc = exp_pc;
      exp_pc = exp_pc + 32'd4;
      n_new++;
    end else begin
      check("bubble_instr", InstrD, NOP_INSTR);
      md_valid = 0;
    end
    if (rsp_now) void'(mq.pop_front());
    if (s_req && c_ready) begin
      check("addr_align", {30'd0, s_addr[1:0]}, 0);
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{s_addr, last_due});
    end
    check("outstanding_le_depth", (mq.size() <= DEPTH), 1);
    if (c_redir) exp_pc = c_tgt;
    p_stall = c_stall;
    p_flush = c_flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    reset = c_rst;
    StallD = c_stall;
    FlushD = c_flush;
    PCSrcE = c_redir;
    PCTargetE = c_tgt;
    bus.imem_ready = c_ready;
    rsp_now = (mq.size() > 0) && (mq[0].due <= cyc) && !c_rst;
    bus.imem_rvalid = rsp_now;
    bus.imem_rdata = rsp_now ? memf(mq[0].addr) : $urandom;
    @(negedge clk);
    s_req = bus.imem_req;
    s_addr = bus.imem_addr;
    s_valid = ValidD;
    s_pcd = PCD;
    monitor();
  endtask

  typedef struct {
    logic        ready;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcd;
  } vec_t;

  vec_t tv[7];

  initial begin
    bit found;
    bit seen;
    int base;

    reset = 1;
    StallD = 0;
    FlushD = 0;
    PCSrcE = 0;
    PCTargetE = 0;
    bus.imem_ready = 1;
    bus.imem_rvalid = 0;
    bus.imem_rdata = 0;

`ifdef FETCH_BYPASS_EN
    tv[0] = '{1, 0, 1, 32'h00, 0, 32'h00};
    tv[1] = '{1, 0, 1, 32'h04, 0, 32'h00};
    tv[2] = '{1, 0, 1, 32'h08, 1, 32'h00};
    tv[3] = '{1, 0, 1, 32'h0C, 1, 32'h04};
    tv[4] = '{1, 0, 1, 32'h10, 1, 32'h08};
    tv[5] = '{1, 0, 1, 32'h14, 1, 32'h0C};
    tv[6] = '{1, 0, 1, 32'h18, 1, 32'h10};
`else
    tv[0] = '{1, 0, 1, 32'h00, 0, 32'h00};
    tv[1] = '{1, 0, 1, 32'h04, 0, 32'h00};
    tv[2] = '{1, 0, 0, 32'h08, 0, 32'h00};
    tv[3] = '{1, 0, 1, 32'h08, 1, 32'h00};
    tv[4] = '{1, 0, 1, 32'h0C, 1, 32'h04};
    tv[5] = '{1, 0, 0, 32'h10, 0, 32'h00};
    tv[6] = '{1, 0, 1, 32'h10, 1, 32'h08};
`endif

    // reset state
    c_rst = 1;
    step();
    step();
    check("rst_validd", ValidD, 0);
    check("rst_instrd", InstrD, NOP_INSTR);
    check("rst_pcd", PCD, 0);
    check("rst_pcplus4d", PCPlus4D, 32'd4);
    check("rst_addr", s_addr, RPC);

    // reset release, single-cycle memory
    c_rst = 0;
    for (int i = 0; i < 7; i++) begin
      c_ready = tv[i].ready;
      c_stall = tv[i].stall;
      step();
      check($sformatf("tbl%0d_req", i), s_req, tv[i].req);
      check($sformatf("tbl%0d_addr", i), s_addr, tv[i].addr);
      check($sformatf("tbl%0d_valid", i), s_valid, tv[i].valid);
      if (tv[i].valid) check($sformatf("tbl%0d_pcd", i), s_pcd, tv[i].pcd);
    end
    repeat (20) step();

    // stall with full queue
    c_stall = 1;
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req_low", s_req, 0);
    end
    c_stall = 0;
    repeat (12) step();

    // redirect with two outstanding
    lat = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) step();
    check("redir_setup_outstanding", mq.size(), 2);
    c_redir = 1;
    c_flush = 1;
    c_tgt = 32'h100;
    step();
    c_redir = 0;
    c_flush = 0;
    step();
    check("redir_next_addr", s_addr, 32'h100);
    found = s_valid;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = s_valid;
    end
    check("redir_found_valid", found, 1);
    check("redir_first_pcd", s_pcd, 32'h100);
    repeat (8) step();

    // imem_ready low for 4 cycles, then 3-cycle latency
    c_ready = 0;
    repeat (4) step();
    c_ready = 1;
    repeat (20) step();

    // address wrap
    lat = 1;
    c_redir = 1;
    c_flush = 1;
    c_tgt = 32'hFFFF_FFF8;
    step();
    c_redir = 0;
    c_flush = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (seen) begin
        check("wrap_addr", s_addr, 32'h0);
        break;
      end
      if (s_req && s_addr == 32'hFFFF_FFFC) seen = 1;
    end
    check("wrap_seen", seen, 1);
    repeat (10) step();

    // reset mid-stream
    c_rst = 1;
    step();
    check("mid_rst_req", s_req, 0);
    c_rst = 0;
    step();
    check("mid_rst_validd", ValidD, 0);
    check("mid_rst_instrd", InstrD, NOP_INSTR);
    check("mid_rst_addr", s_addr, RPC);
    check("mid_rst_pcd", PCD, 0);
    repeat (10) step();

    // randomized traffic
    base = n_new;
    for (int i = 0; i < 1500; i++) begin
      c_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      c_stall = ($urandom_range(0, 4) == 0);
      c_redir = ($urandom_range(0, 28) == 0);
      c_flush = c_redir || ($urandom_range(0, 12) == 0);
      c_tgt = $urandom & 32'hFFFF_FFFC;
      step();
    end
    c_redir = 0;
    c_flush = 0;
    c_stall = 0;
    check("rand_progress", (n_new - base > 50), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
